// File: rtl/cb_dina_map.sv
// RSA result-row to CB port-A write mapper: remaps X lanes onto L banks per direction code
// and paces a burst of sequential writes. Optional write back-pressure: CB_DINA_MAP_STALL_EN.

module cb_dina_lane #(
    parameter int RSA_DW = 16,
    parameter bit NEW_LO = 1'b0,   // bank is written by DIR_NEW when l_k_0=1
    parameter bit NEW_HI = 1'b0    // bank is written by DIR_NEW when l_k_0=0
) (
    input  logic [1:0]        i_dir,
    input  logic              i_lk0,
    input  logic [RSA_DW-1:0] i_pos,
    input  logic [RSA_DW-1:0] i_neg,
    input  logic [RSA_DW-1:0] i_new,
    output logic [RSA_DW-1:0] o_data,
    output logic              o_we
);
    always_comb begin
        o_data = '0;
        o_we   = 1'b0;
        unique case (i_dir)
            2'b01: begin
                o_data = i_pos;
                o_we   = 1'b1;
            end
            2'b10: begin
                o_data = i_neg;
                o_we   = 1'b1;
            end
            2'b11: begin
                if (i_lk0 ? NEW_LO : NEW_HI) begin
                    o_data = i_new;
                    o_we   = 1'b1;
                end
            end
            default: ;
        endcase
    end
endmodule

module cb_dina_map #(
    parameter int X      = 4,
    parameter int L      = 4,
    parameter int RSA_DW = 16,
    parameter int CB_AW  = 10
) (
    input  logic                  clk,
    input  logic                  sys_rst_n,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [1:0]            cmd_dir,
    input  logic                  cmd_l_k_0,
    input  logic [CB_AW-1:0]      cmd_base_addr,
    input  logic [CB_AW-1:0]      cmd_len,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [X*RSA_DW-1:0]   in_data,
`ifdef CB_DINA_MAP_STALL_EN
    input  logic                  cb_wr_ready,
`endif
    output logic                  CB_ena,
    output logic [L-1:0]          CB_wea,
    output logic [CB_AW-1:0]      CB_addra,
    output logic [L*RSA_DW-1:0]   CB_dina,
    output logic                  busy,
    output logic                  done
);
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t                      r_state, w_state_nxt;
    logic [1:0]                  r_dir;
    logic                        r_lk0;
    logic [CB_AW-1:0]            r_base, r_len, r_count;
    logic                        r_ena;
    logic [L-1:0]                r_wea;
    logic [CB_AW-1:0]            r_addr;
    logic [L-1:0][RSA_DW-1:0]    r_dina;

    logic [X-1:0][RSA_DW-1:0]    w_row;
    logic [L-1:0][RSA_DW-1:0]    w_dina;
    logic [L-1:0]                w_wea;
    logic                        w_in_rdy, w_acc, w_release;
    logic [CB_AW-1:0]            w_addr;

    assign w_row  = in_data;
    assign w_addr = r_base + r_count;   // wraps modulo 2^CB_AW
    assign w_acc  = w_in_rdy && in_valid;

    // The presented write may be replaced or retired this cycle.
`ifdef CB_DINA_MAP_STALL_EN
    assign w_release = !r_ena || cb_wr_ready;
`else
    assign w_release = 1'b1;
`endif

    for (genvar g = 0; g < L; g++) begin : g_lane
        localparam int NEW_SRC = (g >= 2) ? g - 2 : g;
        cb_dina_lane #(
            .RSA_DW (RSA_DW),
            .NEW_LO (g < 2),
            .NEW_HI (g >= 2 && g < 4)
        ) u_lane (
            .i_dir  (r_dir),
            .i_lk0  (r_lk0),
            .i_pos  (w_row[g]),
            .i_neg  (w_row[L-1-g]),
            .i_new  (w_row[NEW_SRC]),
            .o_data (w_dina[g]),
            .o_we   (w_wea[g])
        );
    end

    always_comb begin
        w_state_nxt = r_state;
        cmd_ready   = 1'b0;
        w_in_rdy    = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid)
                    w_state_nxt = (cmd_len == '0) ? S_DONE : S_RUN;
            end
            S_RUN: begin
                busy = 1'b1;
`ifdef CB_DINA_MAP_STALL_EN
                // Count reaches len once every row is in; finish when the last write retires.
                w_in_rdy = (r_count != r_len) && w_release;
                if (r_count == r_len && w_release)
                    w_state_nxt = S_DONE;
`else
                w_in_rdy = 1'b1;
                if (in_valid && r_count == r_len - CB_AW'(1))
                    w_state_nxt = S_DONE;
`endif
            end
            S_DONE: begin
                busy        = 1'b1;
                done        = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_state <= S_IDLE;
            r_dir   <= 2'b00;
            r_lk0   <= 1'b0;
            r_base  <= '0;
            r_len   <= '0;
            r_count <= '0;
            r_ena   <= 1'b0;
            r_wea   <= '0;
            r_addr  <= '0;
            r_dina  <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == S_IDLE && cmd_valid) begin
                r_dir   <= cmd_dir;
                r_lk0   <= cmd_l_k_0;
                r_base  <= cmd_base_addr;
                r_len   <= cmd_len;
                r_count <= '0;
            end
            if (w_acc) begin
                r_count <= r_count + CB_AW'(1);
                r_ena   <= (r_dir != 2'b00);
                r_wea   <= w_wea;
                r_dina  <= w_dina;
                r_addr  <= w_addr;
            end else if (w_release) begin
                r_ena <= 1'b0;
                r_wea <= '0;
            end
        end
    end

    assign in_ready = w_in_rdy;
    assign CB_ena   = r_ena;
    assign CB_wea   = r_wea;
    assign CB_addra = r_addr;
    assign CB_dina  = r_dina;
endmodule
